gcd_arbiter: RTL and testbench

Round-robin arbiter that shares one `gcd_top` core among `N_REQ` requesters. It accepts operand pairs through a valid/ready handshake and sequences the core's `start`. It also watches for completion with a watchdog and returns each result to the requester that issued it. The block sits between the requester ports and the single GCD datapath instance.

---
 rtl/gcd_arbiter.sv | 101 ++++++++++
 tb/tb_gcd_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD core among N_REQ requesters with a completion watchdog
module gcd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_A,
  input  logic [N_REQ*WIDTH-1:0] req_B,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_Result,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_A,
  output logic [WIDTH-1:0]       core_B,
  input  logic [WIDTH-1:0]       core_Result,
  input  logic                   core_done,
  output logic                   busy
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  state_t state, nxt;
  logic [GW-1:0] ptr, grant, off, win;
  logic [GW:0] sum;
  logic [N_REQ-1:0] rot;
  logic [WIDTH-1:0] win_a, win_b;
  logic [CW-1:0] cnt;
  logic zero, timeout;
  // round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot = N_REQ'({req_valid, req_valid} >> ptr);
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) off = GW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ)) : GW'(sum);
    win_a = WIDTH'(req_A >> (int'(win) * WIDTH));
    win_b = WIDTH'(req_B >> (int'(win) * WIDTH));
    zero = (win_a == '0) || (win_b == '0);
    timeout = (cnt == CW'(TIMEOUT - 1));
  end
  // next-state: zero operands bypass the core, done beats the watchdog in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !(|req_valid) ? IDLE : zero ? RESPOND : ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (core_done || timeout) ? RESPOND : WAIT;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // request capture, watchdog, result latch and pointer advance
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr        <= '0;
      grant      <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      rsp_Result <= '0;
      rsp_err    <= 1'b0;
      core_A     <= '0;
      core_B     <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE:
          if (|req_valid) begin
            grant     <= win;
            core_A    <= win_a;
            core_B    <= win_b;
            req_ready <= ONE << win;
            if (zero) begin
              rsp_Result <= win_a | win_b;
              rsp_err    <= 1'b0;
            end
          end
        ISSUE: cnt <= '0;
        WAIT:
          if (core_done) begin
            rsp_Result <= core_Result;
            rsp_err    <= 1'b0;
          end else if (timeout) begin
            rsp_Result <= '0;
            rsp_err    <= 1'b1;
          end else cnt <= cnt + CW'(1);
        RESPOND: ptr <= (grant == GW'(N_REQ - 1)) ? '0 : grant + GW'(1);
      endcase
    end
  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESPOND) ? (ONE << grant) : '0;
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed checks of grant order, zero bypass, watchdog, collision and async reset
module tb_gcd_arbiter;
  localparam int N = 4, W = 8, TO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_A = '0, req_B = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [W-1:0] rsp_Result, core_A, core_B;
  logic [W-1:0] core_Result = '0;
  logic rsp_err, core_start, busy;
  logic core_done = 1'b0;
  int n_chk = 0, n_fail = 0, n_start = 0, st0;

  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_Result(rsp_Result), .rsp_err(rsp_err),
    .core_start(core_start), .core_A(core_A), .core_B(core_B), .core_Result(core_Result),
    .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (core_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_A[i*W +: W] = a;
    req_B[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic wait_start();
    int g = 0;
    while (!core_start && g < 20) begin tick(); g++; end
    chk("start_seen", core_start, 1);
  endtask

  task automatic serve(input int idx, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input int lat, input logic [W-1:0] exp, input bit keep);
    int g = 0;
    while (req_ready == '0 && g < 20) begin tick(); g++; end
    chk($sformatf("ready%0d", idx), req_ready, 1 << idx);
    chk($sformatf("start%0d", idx), core_start, 1);
    chk($sformatf("core_A%0d", idx), core_A, ea);
    chk($sformatf("core_B%0d", idx), core_B, eb);
    if (!keep) req_valid[idx] = 1'b0;
    repeat (lat) tick();
    core_done = 1'b1;
    core_Result = gcd(core_A, core_B);
    tick();
    core_done = 1'b0;
    chk($sformatf("rsp_valid%0d", idx), rsp_valid, 1 << idx);
    chk($sformatf("result%0d", idx), rsp_Result, exp);
    chk($sformatf("err%0d", idx), rsp_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_A", core_A, 0);
    reset = 1'b0;
    // single request, core answers 10 cycles after start
    request(0, 64, 8);
    serve(0, 64, 8, 10, 8, 0);
    tick();
    chk("single_idle_rsp", rsp_valid, 0);
    chk("single_idle_busy", busy, 0);
    chk("single_held", rsp_Result, 8);
    // fairness after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request(0, 32, 4);
    request(1, 48, 18);
    request(2, 27, 9);
    request(3, 100, 75);
    serve(0, 32, 4, 3, 4, 1);
    serve(1, 48, 18, 3, 6, 0);
    serve(2, 27, 9, 3, 9, 1);
    serve(3, 100, 75, 3, 25, 0);
    serve(0, 32, 4, 3, 4, 0);
    serve(2, 27, 9, 3, 9, 0);
    // watchdog expiry
    request(3, 10, 4);
    wait_start();
    req_valid[3] = 1'b0;
    repeat (TO) tick();
    chk("to_last_wait_rsp", rsp_valid, 0);
    chk("to_last_wait_busy", busy, 1);
    tick();
    chk("to_rsp_valid", rsp_valid, 4'b1000);
    chk("to_err", rsp_err, 1);
    chk("to_result", rsp_Result, 0);
    tick();
    chk("to_err_held", rsp_err, 1);
    chk("to_rsp_drop", rsp_valid, 0);
    request(1, 15, 5);
    serve(1, 15, 5, 2, 5, 0);
    // zero operands bypass the core
    tick();
    st0 = n_start;
    request(1, 0, 12);
    tick();
    chk("z1_ready", req_ready, 4'b0010);
    chk("z1_rsp_valid", rsp_valid, 4'b0010);
    chk("z1_result", rsp_Result, 12);
    chk("z1_err", rsp_err, 0);
    chk("z1_start", core_start, 0);
    req_valid[1] = 1'b0;
    tick();
    request(1, 0, 0);
    tick();
    chk("z2_ready", req_ready, 4'b0010);
    chk("z2_rsp_valid", rsp_valid, 4'b0010);
    chk("z2_result", rsp_Result, 0);
    chk("z2_err", rsp_err, 0);
    req_valid[1] = 1'b0;
    chk("z_no_start", n_start - st0, 0);
    // done on the last WAIT cycle beats the watchdog
    request(0, 21, 14);
    wait_start();
    req_valid[0] = 1'b0;
    repeat (TO) tick();
    chk("col_last_wait_rsp", rsp_valid, 0);
    chk("col_last_wait_busy", busy, 1);
    core_done = 1'b1;
    core_Result = gcd(core_A, core_B);
    tick();
    core_done = 1'b0;
    chk("col_rsp_valid", rsp_valid, 4'b0001);
    chk("col_err", rsp_err, 0);
    chk("col_result", rsp_Result, 7);
    // asynchronous reset during WAIT
    request(2, 30, 12);
    wait_start();
    req_valid[2] = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    chk("mid_core_A", core_A, 30);
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", req_ready, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_result", rsp_Result, 0);
    chk("ar_err", rsp_err, 0);
    chk("ar_start", core_start, 0);
    chk("ar_core_A", core_A, 0);
    chk("ar_core_B", core_B, 0);
    repeat (2) tick();
    chk("ar_no_rsp", rsp_valid, 0);
    reset = 1'b0;
    request(2, 30, 12);
    request(0, 9, 6);
    serve(0, 9, 6, 2, 3, 0);
    serve(2, 30, 12, 2, 6, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
